// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (default 8N1, LSB first).
// It runs on the rx_bd_en tick from the baud generator, which fires OVERSAMPLE
// times per bit. Each bit is the 2-of-3 majority of the samples taken at ticks
// M-1, M and M+1, where M = OVERSAMPLE/2.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   rx_bd_en       oversample tick, one clk wide
//   rxd            asynchronous serial line, idle high
//   rx_data        last good byte, held until the next good byte arrives
//   rx_valid       1-clk strobe: rx_data was updated this cycle
//   rx_frame_err   1-clk strobe: the stop bit was sampled low
//   rx_parity_err  1-clk strobe: parity mismatch with a good stop bit
//   rx_busy        high while the FSM is not in IDLE
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bd_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;

  state_t               state;
  logic                 rxd_meta, rxd_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 s0, s1, par_bit;
  logic                 maj, parity_bad;

  // Two-FF synchroniser. It resets to 1 (the idle level) so that leaving
  // reset cannot look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // The third sample is the live rxd_s at tick M+1, so each bit is decided
  // on that tick without waiting one more tick.
  assign maj        = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
  assign parity_bad = ((^shift) ^ par_bit) != PAR_ODD;
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      s0            <= 1'b1;
      s1            <= 1'b1;
      par_bit       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      if (rx_bd_en) begin
        if (tick_cnt == T_S0) s0 <= rxd_s;
        if (tick_cnt == T_S1) s1 <= rxd_s;
        // In every state except IDLE the tick counter free-runs. The case
        // branches below override it when they reset the bit timing.
        if (state != IDLE)
          tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state    <= START;
              tick_cnt <= TW'(1);  // the detecting tick is tick 0
            end else begin
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == T_S2 && maj) begin
              state    <= IDLE;    // the low pulse was a glitch
              tick_cnt <= '0;
            end else if (tick_cnt == T_LAST) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (tick_cnt == T_S2) shift <= {maj, shift[DATA_BITS-1:1]};
            if (tick_cnt == T_LAST) begin
              if (bit_cnt == B_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
              else                   bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == T_S2)   par_bit <= maj;
            if (tick_cnt == T_LAST) state   <= STOP;
          end
          STOP: begin
            // Decide at mid stop bit. Leaving here early lets a back-to-back
            // start edge be seen as soon as it arrives.
            if (tick_cnt == T_S2) begin
              tick_cnt <= '0;
              if (!maj) begin
                rx_frame_err <= 1'b1;
                state        <= WAIT_HI;
              end else if (PARITY_EN != 0 && parity_bad) begin
                rx_parity_err <= 1'b1;
                state         <= IDLE;
              end else begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          WAIT_HI: begin
            // A break or a stuck-low line must go high before the next frame.
            if (rxd_s) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os. It uses two instances: an 8N1 receiver and an
// 8E1 receiver. Each expected strobe (kind plus rx_data) is queued before its
// frame is driven. A monitor pops and compares an entry on every strobe.
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int BIT_CLK = 868;
  localparam int BD_DIV  = 108;

  typedef enum logic [1:0] {EV_VALID, EV_FRAME, EV_PARITY} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0, rst = 1'b1, bd_en = 1'b0, rxd_a = 1'b1, rxd_p = 1'b1;
  logic [7:0] rx_data_a, rx_data_p;
  logic rx_valid_a, rx_frame_err_a, rx_parity_err_a, rx_busy_a;
  logic rx_valid_p, rx_frame_err_p, rx_parity_err_p, rx_busy_p;

  ev_t exp_a[$];
  ev_t exp_p[$];
  int  checks = 0, errors = 0;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rx_bd_en(bd_en), .rxd(rxd_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_frame_err(rx_frame_err_a),
    .rx_parity_err(rx_parity_err_a), .rx_busy(rx_busy_a));

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .rx_bd_en(bd_en), .rxd(rxd_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_frame_err(rx_frame_err_p),
    .rx_parity_err(rx_parity_err_p), .rx_busy(rx_busy_p));

  always #5 clk = ~clk;

  // Baud tick: one clk wide, once every BD_DIV clocks.
  initial begin
    forever begin
      repeat (BD_DIV - 1) @(posedge clk);
      #1 bd_en = 1'b1;
      @(posedge clk);
      #1 bd_en = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int         na, np;
  ev_t        ea, ep;
  ev_kind_t   ka, kp;

  always @(negedge clk) begin
    if (!rst) begin
      na = int'(rx_valid_a) + int'(rx_frame_err_a) + int'(rx_parity_err_a);
      if (na != 0) begin
        chk("a_one_strobe", na, 1);
        chk("a_strobe_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) begin
          ea = exp_a.pop_front();
          ka = rx_valid_a ? EV_VALID : (rx_frame_err_a ? EV_FRAME : EV_PARITY);
          chk("a_kind", ka, ea.kind);
          chk("a_data", rx_data_a, ea.data);
        end
      end
      np = int'(rx_valid_p) + int'(rx_frame_err_p) + int'(rx_parity_err_p);
      if (np != 0) begin
        chk("p_one_strobe", np, 1);
        chk("p_strobe_expected", exp_p.size() != 0, 1);
        if (exp_p.size() != 0) begin
          ep = exp_p.pop_front();
          kp = rx_valid_p ? EV_VALID : (rx_frame_err_p ? EV_FRAME : EV_PARITY);
          chk("p_kind", kp, ep.kind);
          chk("p_data", rx_data_p, ep.data);
        end
      end
    end
  end

  task automatic drive(input bit p, input logic v, input int ncyc);
    if (p) rxd_p = v;
    else   rxd_a = v;
    repeat (ncyc) @(posedge clk);
  endtask

  task automatic send_frame(input bit p, input logic [7:0] d, input logic stop,
                            input bit use_par, input logic par);
    drive(p, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(p, d[i], BIT_CLK);
    if (use_par) drive(p, par, BIT_CLK);
    drive(p, stop, BIT_CLK);
  endtask

  task automatic expect_a(input ev_kind_t k, input logic [7:0] d);
    exp_a.push_back('{kind: k, data: d});
  endtask

  task automatic expect_p(input ev_kind_t k, input logic [7:0] d);
    exp_p.push_back('{kind: k, data: d});
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data", rx_data_a, 8'h00);
    chk("rst_valid", rx_valid_a, 1'b0);
    chk("rst_frame", rx_frame_err_a, 1'b0);
    chk("rst_parity", rx_parity_err_a, 1'b0);
    chk("rst_busy", rx_busy_a, 1'b0);
    chk("rst_busy_p", rx_busy_p, 1'b0);
    rst = 1'b0;
    drive(0, 1'b1, BIT_CLK);

    // Single 8N1 byte
    expect_a(EV_VALID, 8'h55);
    send_frame(0, 8'h55, 1'b1, 0, 1'b0);
    drive(0, 1'b1, BIT_CLK/2);
    @(negedge clk);
    chk("t1_data", rx_data_a, 8'h55);
    chk("t1_busy", rx_busy_a, 1'b0);
    chk("t1_pending", exp_a.size(), 0);

    // Back-to-back frames with no idle gap
    expect_a(EV_VALID, 8'hA3);
    expect_a(EV_VALID, 8'h0F);
    send_frame(0, 8'hA3, 1'b1, 0, 1'b0);
    send_frame(0, 8'h0F, 1'b1, 0, 1'b0);
    drive(0, 1'b1, BIT_CLK/2);
    @(negedge clk);
    chk("t2_data", rx_data_a, 8'h0F);
    chk("t2_pending", exp_a.size(), 0);

    // Short low glitch on an idle line
    drive(0, 1'b0, 200);
    drive(0, 1'b1, BIT_CLK);
    @(negedge clk);
    chk("t3_busy", rx_busy_a, 1'b0);
    chk("t3_data", rx_data_a, 8'h0F);

    // Framing error followed by a break, then a good byte
    expect_a(EV_FRAME, 8'h0F);
    send_frame(0, 8'h3C, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("t4_busy_in_break", rx_busy_a, 1'b1);
    drive(0, 1'b0, 2*BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    @(negedge clk);
    chk("t4_pending", exp_a.size(), 0);
    chk("t4_data_held", rx_data_a, 8'h0F);
    expect_a(EV_VALID, 8'h81);
    send_frame(0, 8'h81, 1'b1, 0, 1'b0);
    drive(0, 1'b1, BIT_CLK/2);
    @(negedge clk);
    chk("t4_data", rx_data_a, 8'h81);
    chk("t4_pending2", exp_a.size(), 0);

    // Even parity: 0x07 has three ones, so the parity bit must be 1
    expect_p(EV_VALID, 8'h07);
    send_frame(1, 8'h07, 1'b1, 1, 1'b1);
    drive(1, 1'b1, BIT_CLK/2);
    @(negedge clk);
    chk("t5_data", rx_data_p, 8'h07);
    expect_p(EV_PARITY, 8'h07);
    send_frame(1, 8'h07, 1'b1, 1, 1'b0);
    drive(1, 1'b1, BIT_CLK/2);
    @(negedge clk);
    chk("t5_data_held", rx_data_p, 8'h07);
    chk("t5_pending", exp_p.size(), 0);
    chk("t5_busy", rx_busy_p, 1'b0);

    // Reset during the 4th data bit of 0xFF
    drive(0, 1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, BIT_CLK);
    drive(0, 1'b1, 400);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_rst_data", rx_data_a, 8'h00);
    chk("t6_rst_busy", rx_busy_a, 1'b0);
    chk("t6_rst_data_p", rx_data_p, 8'h00);
    rst = 1'b0;
    drive(0, 1'b1, 5*BIT_CLK);
    @(negedge clk);
    chk("t6_busy_after", rx_busy_a, 1'b0);
    expect_a(EV_VALID, 8'h12);
    send_frame(0, 8'h12, 1'b1, 0, 1'b0);
    drive(0, 1'b1, BIT_CLK/2);
    @(negedge clk);
    chk("t6_data", rx_data_a, 8'h12);
    chk("t6_pending", exp_a.size(), 0);
    chk("t6_pending_p", exp_p.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
